// File: rtl/retro_memory_copier_pkg.sv
// Shared types and helpers for the block-copy engine.
// - copier_state_t : FSM encoding (idle, read, capture, write, done)
// - mask_all()     : all-ones byte mask for a given bus width in bytes
package retro_memory_copier_pkg;

  localparam int unsigned MaxDataBusWidth = 16;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StCap,
    StWr,
    StDone
  } copier_state_t;

  function automatic logic [MaxDataBusWidth-1:0] mask_all(input int unsigned width);
    logic [MaxDataBusWidth-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MaxDataBusWidth; i++) begin
      if (i < width) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/retro_memory_copier_if.sv
// Word-addressed memory port between an initiator (copier) and a target (BRAM/SRAM).
// - clk            : clock forwarded by the initiator
// - access/write   : request valid / write not read
// - address        : word address
// - mask           : byte-enable, one bit per byte
// - d_to_target    : write data
// - ready          : target accepts the request this cycle
// - data_ready     : read data will be valid on d_to_initiator the following cycle
// - d_to_initiator : read data
interface retro_memory_copier_if #(
  parameter int unsigned AddressBusWidth = 12,
  parameter int unsigned DataBusWidth    = 1
);

  logic                         clk;
  logic                         access;
  logic                         write;
  logic [AddressBusWidth-1:0]   address;
  logic [DataBusWidth-1:0]      mask;
  logic [8*DataBusWidth-1:0]    d_to_target;
  logic                         ready;
  logic                         data_ready;
  logic [8*DataBusWidth-1:0]    d_to_initiator;

  modport initiator (
    output clk, access, write, address, mask, d_to_target,
    input  ready, data_ready, d_to_initiator
  );

  modport target (
    input  clk, access, write, address, mask, d_to_target,
    output ready, data_ready, d_to_initiator
  );

endinterface

// File: rtl/retro_memory_copier.sv
// Block-copy engine: on start, copies length words from src_addr to dst_addr through one
// memory port, one read then one write per word, ascending addresses with wrap-around.
// Ports:
// - clk, rst      : system clock, asynchronous active-high reset
// - start_i       : one-cycle request, sampled only while idle
// - src_addr_i    : first source word address (latched on start)
// - dst_addr_i    : first destination word address (latched on start)
// - length_i      : word count (latched on start), zero is legal
// - busy_o        : high in every non-idle state
// - done_o        : one-cycle pulse when the copy completes
// - mem           : memory port, initiator side
module retro_memory_copier
  import retro_memory_copier_pkg::*;
#(
  parameter int unsigned AddressBusWidth = 12,
  parameter int unsigned DataBusWidth    = 1,
  parameter int unsigned LengthWidth     = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic [AddressBusWidth-1:0] src_addr_i,
  input  logic [AddressBusWidth-1:0] dst_addr_i,
  input  logic [LengthWidth-1:0]     length_i,
  output logic                       busy_o,
  output logic                       done_o,
  retro_memory_copier_if.initiator   mem
);

  localparam int unsigned DataWidth = 8 * DataBusWidth;
  localparam logic [DataBusWidth-1:0] MaskOnes = DataBusWidth'(mask_all(DataBusWidth));

  copier_state_t state_q, state_d;

  logic [AddressBusWidth-1:0] src_q, src_d;
  logic [AddressBusWidth-1:0] dst_q, dst_d;
  logic [LengthWidth-1:0]     remaining_q, remaining_d;
  logic [DataWidth-1:0]       data_q, data_d;

  // Port outputs are registered; their next values are derived from the next state.
  logic                       access_q, access_d;
  logic                       write_q, write_d;
  logic [AddressBusWidth-1:0] address_q, address_d;
  logic [DataBusWidth-1:0]    mask_q, mask_d;
  logic [DataWidth-1:0]       d_to_target_q, d_to_target_d;
  logic                       done_q, done_d;

  // State, counters, pointers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      src_q         <= '0;
      dst_q         <= '0;
      remaining_q   <= '0;
      data_q        <= '0;
      access_q      <= 1'b0;
      write_q       <= 1'b0;
      address_q     <= '0;
      mask_q        <= '0;
      d_to_target_q <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      src_q         <= src_d;
      dst_q         <= dst_d;
      remaining_q   <= remaining_d;
      data_q        <= data_d;
      access_q      <= access_d;
      write_q       <= write_d;
      address_q     <= address_d;
      mask_q        <= mask_d;
      d_to_target_q <= d_to_target_d;
      done_q        <= done_d;
    end
  end

  // Next state, pointers and word counter.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    remaining_d = remaining_q;
    data_d      = data_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          src_d       = src_addr_i;
          dst_d       = dst_addr_i;
          remaining_d = length_i;
          state_d     = (length_i == '0) ? StDone : StRd;
        end
      end
      StRd: begin
        if (mem.ready && mem.data_ready) state_d = StCap;
      end
      StCap: begin
        // Read data arrives the cycle after the target accepted the read.
        data_d  = mem.d_to_initiator;
        state_d = StWr;
      end
      StWr: begin
        if (mem.ready) begin
          src_d       = src_q + 1'b1;
          dst_d       = dst_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          state_d     = (remaining_q == LengthWidth'(1)) ? StDone : StRd;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Registered-output next values; stable during stalls because src_d/dst_d/data_d hold.
  always_comb begin
    access_d      = 1'b0;
    write_d       = 1'b0;
    address_d     = '0;
    mask_d        = '0;
    d_to_target_d = '0;
    done_d        = 1'b0;
    unique case (state_d)
      StRd: begin
        access_d  = 1'b1;
        address_d = src_d;
      end
      StWr: begin
        access_d      = 1'b1;
        write_d       = 1'b1;
        address_d     = dst_d;
        mask_d        = MaskOnes;
        d_to_target_d = data_d;
      end
      StDone: done_d = 1'b1;
      default: ;
    endcase
  end

  assign busy_o          = (state_q != StIdle);
  assign done_o          = done_q;
  assign mem.clk         = clk;
  assign mem.access      = access_q;
  assign mem.write       = write_q;
  assign mem.address     = address_q;
  assign mem.mask        = mask_q;
  assign mem.d_to_target = d_to_target_q;

endmodule

// File: tb/tb_retro_memory_copier.sv
// Directed bench: a zero-wait 8-bit BRAM model on instance A and a randomly stalling 16-bit
// model on instance B.
module tb_retro_memory_copier;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: 12/1, zero-wait target
  logic        start_a;
  logic [11:0] src_a, dst_a, len_a;
  logic        busy_a, done_a;
  retro_memory_copier_if #(.AddressBusWidth(12), .DataBusWidth(1)) mem_a ();

  retro_memory_copier #(.AddressBusWidth(12), .DataBusWidth(1), .LengthWidth(12)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_a),
    .src_addr_i (src_a),
    .dst_addr_i (dst_a),
    .length_i   (len_a),
    .busy_o     (busy_a),
    .done_o     (done_a),
    .mem        (mem_a.initiator)
  );

  logic [7:0] arr_a [0:4095];
  int         wr_cnt_a = 0;
  assign mem_a.ready      = 1'b1;
  assign mem_a.data_ready = mem_a.access & ~mem_a.write;
  always @(posedge clk) begin
    if (mem_a.access) begin
      if (mem_a.write) begin
        if (mem_a.mask[0]) arr_a[mem_a.address] <= mem_a.d_to_target;
        wr_cnt_a <= wr_cnt_a + 1;
      end else begin
        mem_a.d_to_initiator <= arr_a[mem_a.address];
      end
    end
  end

  // Instance B: 12/2, target inserts 1..5 Ready=0 cycles before every acceptance
  logic        start_b;
  logic [11:0] src_b, dst_b, len_b;
  logic        busy_b, done_b;
  retro_memory_copier_if #(.AddressBusWidth(12), .DataBusWidth(2)) mem_b ();

  retro_memory_copier #(.AddressBusWidth(12), .DataBusWidth(2), .LengthWidth(12)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_b),
    .src_addr_i (src_b),
    .dst_addr_i (dst_b),
    .length_i   (len_b),
    .busy_o     (busy_b),
    .done_o     (done_b),
    .mem        (mem_b.initiator)
  );

  logic [15:0] arr_b [0:4095];
  int          stall_b = 3;
  assign mem_b.ready      = (stall_b == 0);
  assign mem_b.data_ready = mem_b.access & ~mem_b.write & mem_b.ready;
  always @(posedge clk) begin
    if (!mem_b.access || mem_b.ready) stall_b <= int'($urandom_range(5, 1));
    else stall_b <= stall_b - 1;
    if (mem_b.access && mem_b.ready) begin
      if (mem_b.write) begin
        if (mem_b.mask[0]) arr_b[mem_b.address][7:0]  <= mem_b.d_to_target[7:0];
        if (mem_b.mask[1]) arr_b[mem_b.address][15:8] <= mem_b.d_to_target[15:8];
      end else begin
        mem_b.d_to_initiator <= arr_b[mem_b.address];
      end
    end
  end

  // Runs one copy on instance A. Cycle 1 is the cycle after start is sampled.
  // glitch_at: cycle in which a second start (0xABC -> 0xC00, len 2) is driven.
  // abort_at : cycle in which rst is raised; access is sampled 1 time unit later.
  task automatic run_a(input logic [11:0] s, input logic [11:0] d, input logic [11:0] n,
                       input int glitch_at, input int abort_at,
                       output int done_at, output int ndone, output int nacc,
                       output logic busy_after, output logic acc_abort);
    int cyc;
    done_at = -1; ndone = 0; nacc = 0; busy_after = 1'b1; acc_abort = 1'b1;
    @(negedge clk);
    start_a = 1'b1; src_a = s; dst_a = d; len_a = n;
    @(negedge clk);
    start_a = 1'b0;
    cyc = 1;
    while (cyc < 2000) begin
      if (cyc == abort_at) begin
        rst = 1'b1;
        #1;
        acc_abort = mem_a.access;
        break;
      end
      if (done_a) begin
        ndone++;
        if (done_at < 0) done_at = cyc;
      end
      if (mem_a.access) nacc++;
      if (done_at >= 0 && cyc == done_at + 2) busy_after = busy_a;
      if (done_at >= 0 && cyc >= done_at + 3) break;
      if (cyc == glitch_at) begin
        start_a = 1'b1; src_a = 12'hABC; dst_a = 12'hC00; len_a = 12'd2;
      end else begin
        start_a = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start_a = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_a); end
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done_a); end
    checks++; if (mem_a.access !== 1'b0 || mem_a.write !== 1'b0) begin
      errors++; $display("FAIL reset_access got %b%b want 00", mem_a.access, mem_a.write); end
    checks++; if (mem_a.address !== 12'h000) begin
      errors++; $display("FAIL reset_address got %h want 000", mem_a.address); end
    checks++; if (mem_a.mask !== 1'b0 || mem_a.d_to_target !== 8'h00) begin
      errors++; $display("FAIL reset_mask_data got %b/%h want 0/00", mem_a.mask, mem_a.d_to_target); end
    checks++; if (mem_b.access !== 1'b0 || mem_b.mask !== 2'b00 || busy_b !== 1'b0) begin
      errors++; $display("FAIL reset_b got acc=%b mask=%b busy=%b want 0/00/0",
                         mem_b.access, mem_b.mask, busy_b); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_copy();
    int done_at, ndone, nacc, wr0;
    logic busy_after, acc_abort;
    for (int i = 0; i < 16; i++) begin
      arr_a[i] = 8'(8'hA0 + i);
      arr_a[12'h100 + i] = 8'h00;
    end
    wr0 = wr_cnt_a;
    run_a(12'h000, 12'h100, 12'd16, -1, -1, done_at, ndone, nacc, busy_after, acc_abort);
    checks++; if (done_at != 49) begin errors++; $display("FAIL basic_done_cycle got %0d want 49", done_at); end
    checks++; if (ndone != 1) begin errors++; $display("FAIL basic_done_pulses got %0d want 1", ndone); end
    checks++; if (nacc != 32) begin errors++; $display("FAIL basic_access_cycles got %0d want 32", nacc); end
    checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL basic_idle_after got %b want 0", busy_after); end
    checks++; if (wr_cnt_a - wr0 != 16) begin
      errors++; $display("FAIL basic_write_count got %0d want 16", wr_cnt_a - wr0); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (arr_a[12'h100 + i] !== 8'(8'hA0 + i)) begin
        errors++; $display("FAIL basic_data[%0d] got %h want %h", i, arr_a[12'h100 + i], 8'(8'hA0 + i));
      end
    end
  endtask

  task automatic test_zero_length();
    int done_at, ndone, nacc, wr0;
    logic busy_after, acc_abort;
    arr_a[12'h200] = 8'h77;
    wr0 = wr_cnt_a;
    run_a(12'h123, 12'h200, 12'd0, -1, -1, done_at, ndone, nacc, busy_after, acc_abort);
    checks++; if (done_at != 1) begin errors++; $display("FAIL zero_done_cycle got %0d want 1", done_at); end
    checks++; if (nacc != 0) begin errors++; $display("FAIL zero_access got %0d want 0", nacc); end
    checks++; if (wr_cnt_a != wr0) begin errors++; $display("FAIL zero_writes got %0d want 0", wr_cnt_a - wr0); end
    checks++; if (arr_a[12'h200] !== 8'h77) begin
      errors++; $display("FAIL zero_mem got %h want 77", arr_a[12'h200]); end
  endtask

  task automatic test_wrap();
    int done_at, ndone, nacc;
    logic busy_after, acc_abort;
    logic [7:0] exp [4];
    exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33; exp[3] = 8'h44;
    arr_a[12'hFFE] = 8'h11; arr_a[12'hFFF] = 8'h22; arr_a[12'h000] = 8'h33; arr_a[12'h001] = 8'h44;
    for (int i = 0; i < 4; i++) arr_a[12'h7FE + i] = 8'h00;
    run_a(12'hFFE, 12'h7FE, 12'd4, -1, -1, done_at, ndone, nacc, busy_after, acc_abort);
    checks++; if (done_at != 13) begin errors++; $display("FAIL wrap_done_cycle got %0d want 13", done_at); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (arr_a[12'h7FE + i] !== exp[i]) begin
        errors++; $display("FAIL wrap_read[%0d] got %h want %h", i, arr_a[12'h7FE + i], exp[i]);
      end
    end
    run_a(12'h7FE, 12'hFFF, 12'd2, -1, -1, done_at, ndone, nacc, busy_after, acc_abort);
    checks++; if (arr_a[12'hFFF] !== 8'h11) begin errors++; $display("FAIL wrap_write_fff got %h want 11", arr_a[12'hFFF]); end
    checks++; if (arr_a[12'h000] !== 8'h22) begin errors++; $display("FAIL wrap_write_000 got %h want 22", arr_a[12'h000]); end
    checks++; if (arr_a[12'h001] !== 8'h44) begin errors++; $display("FAIL wrap_write_001 got %h want 44", arr_a[12'h001]); end
  endtask

  task automatic test_stalls();
    int cyc, stalls;
    logic seen_done, prev_acc, prev_rdy, prev_wr;
    logic [11:0] prev_addr;
    logic [15:0] prev_dtt;
    logic [1:0] exp_mask;
    logic [15:0] exp [4];
    exp[0] = 16'h1234; exp[1] = 16'h2345; exp[2] = 16'h3456; exp[3] = 16'h4567;
    for (int i = 0; i < 4; i++) begin
      arr_b[12'h020 + i] = exp[i];
      arr_b[12'h200 + i] = 16'h0000;
    end
    stalls = 0; seen_done = 1'b0; prev_acc = 1'b0; prev_rdy = 1'b1; prev_wr = 1'b0;
    prev_addr = '0; prev_dtt = '0;
    @(negedge clk);
    start_b = 1'b1; src_b = 12'h020; dst_b = 12'h200; len_b = 12'd4;
    @(negedge clk);
    start_b = 1'b0;
    cyc = 1;
    while (cyc < 1000 && !seen_done) begin
      if (prev_acc && !prev_rdy) begin
        stalls++;
        checks++;
        if (mem_b.access !== 1'b1 || mem_b.address !== prev_addr || mem_b.write !== prev_wr ||
            mem_b.d_to_target !== prev_dtt) begin
          errors++;
          $display("FAIL stall_hold cyc %0d got acc=%b a=%h w=%b d=%h want 1 %h %b %h", cyc,
                   mem_b.access, mem_b.address, mem_b.write, mem_b.d_to_target,
                   prev_addr, prev_wr, prev_dtt);
        end
      end
      exp_mask = (mem_b.access && mem_b.write) ? 2'b11 : 2'b00;
      checks++;
      if (mem_b.mask !== exp_mask) begin
        errors++; $display("FAIL stall_mask cyc %0d got %b want %b", cyc, mem_b.mask, exp_mask);
      end
      if (done_b) seen_done = 1'b1;
      prev_acc = mem_b.access; prev_rdy = mem_b.ready; prev_wr = mem_b.write;
      prev_addr = mem_b.address; prev_dtt = mem_b.d_to_target;
      @(negedge clk);
      cyc++;
    end
    checks++; if (!seen_done) begin errors++; $display("FAIL stall_done got 0 want 1 within 1000 cycles"); end
    checks++; if (stalls == 0) begin errors++; $display("FAIL stall_seen got 0 want >0"); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (arr_b[12'h200 + i] !== exp[i]) begin
        errors++; $display("FAIL stall_data[%0d] got %h want %h", i, arr_b[12'h200 + i], exp[i]);
      end
    end
  endtask

  task automatic test_start_ignored();
    int done_at, ndone, nacc;
    logic busy_after, acc_abort;
    for (int i = 0; i < 8; i++) begin
      arr_a[12'h300 + i] = 8'(8'hC0 + i);
      arr_a[12'h400 + i] = 8'h00;
    end
    arr_a[12'hC00] = 8'hEE; arr_a[12'hC01] = 8'hEE;
    arr_a[12'h500] = 8'h00;
    run_a(12'h300, 12'h400, 12'd8, 5, -1, done_at, ndone, nacc, busy_after, acc_abort);
    checks++; if (done_at != 25) begin errors++; $display("FAIL busy_start_done got %0d want 25", done_at); end
    checks++; if (ndone != 1) begin errors++; $display("FAIL busy_start_pulses got %0d want 1", ndone); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (arr_a[12'h400 + i] !== 8'(8'hC0 + i)) begin
        errors++; $display("FAIL busy_start_data[%0d] got %h want %h", i, arr_a[12'h400 + i], 8'(8'hC0 + i));
      end
    end
    // Start driven in the DONE cycle (cycle 4 for a one-word copy).
    run_a(12'h300, 12'h500, 12'd1, 4, -1, done_at, ndone, nacc, busy_after, acc_abort);
    checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL done_start_busy got %b want 0", busy_after); end
    checks++; if (ndone != 1) begin errors++; $display("FAIL done_start_pulses got %0d want 1", ndone); end
    checks++; if (arr_a[12'h500] !== 8'hC0) begin errors++; $display("FAIL done_start_data got %h want c0", arr_a[12'h500]); end
    checks++; if (arr_a[12'hC00] !== 8'hEE || arr_a[12'hC01] !== 8'hEE) begin
      errors++; $display("FAIL alt_dst_touched got %h%h want eeee", arr_a[12'hC00], arr_a[12'hC01]); end
  endtask

  task automatic test_reset_abort();
    int done_at, ndone, nacc;
    logic busy_after, acc_abort;
    for (int i = 0; i < 8; i++) begin
      arr_a[12'h600 + i] = 8'(8'hD0 + i);
      arr_a[12'h700 + i] = 8'h00;
    end
    // Word 3 read phase occupies cycle 10.
    run_a(12'h600, 12'h700, 12'd8, -1, 10, done_at, ndone, nacc, busy_after, acc_abort);
    checks++; if (acc_abort !== 1'b0) begin errors++; $display("FAIL abort_access got %b want 0", acc_abort); end
    checks++; if (ndone != 0) begin errors++; $display("FAIL abort_done got %0d want 0", ndone); end
    repeat (2) @(negedge clk);
    checks++; if (done_a !== 1'b0 || busy_a !== 1'b0) begin
      errors++; $display("FAIL abort_state got done=%b busy=%b want 0/0", done_a, busy_a); end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (arr_a[12'h700 + i] !== ((i < 3) ? 8'(8'hD0 + i) : 8'h00)) begin
        errors++; $display("FAIL abort_data[%0d] got %h want %h", i, arr_a[12'h700 + i],
                           (i < 3) ? 8'(8'hD0 + i) : 8'h00);
      end
    end
    run_a(12'h600, 12'h700, 12'd8, -1, -1, done_at, ndone, nacc, busy_after, acc_abort);
    checks++; if (done_at != 25) begin errors++; $display("FAIL rerun_done got %0d want 25", done_at); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (arr_a[12'h700 + i] !== 8'(8'hD0 + i)) begin
        errors++; $display("FAIL rerun_data[%0d] got %h want %h", i, arr_a[12'h700 + i], 8'(8'hD0 + i));
      end
    end
  endtask

  task automatic test_overlap();
    int done_at, ndone, nacc;
    logic busy_after, acc_abort;
    arr_a[12'h010] = 8'h55;
    for (int i = 1; i < 5; i++) arr_a[12'h010 + i] = 8'(i);
    arr_a[12'h015] = 8'h99;
    run_a(12'h010, 12'h011, 12'd4, -1, -1, done_at, ndone, nacc, busy_after, acc_abort);
    for (int i = 1; i < 5; i++) begin
      checks++;
      if (arr_a[12'h010 + i] !== 8'h55) begin
        errors++; $display("FAIL overlap[%0d] got %h want 55", i, arr_a[12'h010 + i]);
      end
    end
    checks++; if (arr_a[12'h015] !== 8'h99) begin errors++; $display("FAIL overlap_tail got %h want 99", arr_a[12'h015]); end
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0; src_a = '0; dst_a = '0; len_a = '0;
    start_b = 1'b0; src_b = '0; dst_b = '0; len_b = '0;
    test_reset();
    test_basic_copy();
    test_zero_length();
    test_wrap();
    test_stalls();
    test_start_ignored();
    test_reset_abort();
    test_overlap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
